tisc_wb_decoder: RTL

Parametrised WISHBONE address decoder and response multiplexer between the PCI bridge's WISHBONE master port and N register slaves (identification, GLITC configuration controller, GLITCBUS master, ...). It replaces hand-wired combinational select/ack muxing with a registered single-outstanding-transaction engine. It adds:
- a per-access watchdog that converts a silent slave into a bus error;
- decode-error reporting for unmapped indices;
- error status (count and faulting address) readable by software.

---
 rtl/tisc_wb_pkg.sv | 30 +++
 rtl/tisc_wb_watchdog.sv | 46 ++++
 rtl/tisc_wb_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tisc_wb_pkg.sv
// Shared types and helpers for the WISHBONE slave decoder: bus widths, FSM states, index extraction.
package tisc_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Gathers the address bits selected by mask; the lowest set mask bit becomes index bit 0.
    function automatic logic [WB_AW-1:0] wb_extract_idx(input logic [WB_AW-1:0] adr,
                                                        input logic [WB_AW-1:0] mask);
        logic [WB_AW-1:0] idx;
        int               n;
        idx = '0;
        n   = 0;
        for (int i = 0; i < WB_AW; i++) begin
            if (mask[i]) begin
                idx[n[4:0]] = adr[i];
                n++;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tisc_wb_watchdog.sv
// Counts ACTIVE cycles and pulses expire_o in the TIMEOUT-th enabled cycle; clear has priority.
// Combinational expire from registered count; TIMEOUT = 0 ties expire_o low.
module tisc_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic wd_unused;
            assign wd_unused = ^{clk_i, rst_i, clr_i, en_i};
            assign expire_o  = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Count starts at 0 in the first ACTIVE cycle, so TIMEOUT-1 marks the last one.
            assign expire_o = en_i & ~clr_i & (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/tisc_wb_decoder.sv
// WISHBONE address decoder / response mux, one outstanding access; master ack 2 cycles after stb for a zero-wait slave.
// Master is held off until the slave responds, the watchdog expires, or cyc_i drops; decode/timeout errors are counted.
module tisc_wb_decoder
    import tisc_wb_pkg::*;
#(
    parameter int          NSLAVES  = 4,
    parameter logic [31:0] SEL_MASK = 32'h0004_0010,
    parameter int          TIMEOUT  = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_AW-1:0]         adr_i,
    input  logic [WB_DW-1:0]         dat_i,
    input  logic [WB_SW-1:0]         sel_i,
    output logic [WB_DW-1:0]         dat_o,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     rty_o,
    output logic                     s_cyc_o,
    output logic [NSLAVES-1:0]       s_stb_o,
    output logic                     s_we_o,
    output logic [WB_AW-1:0]         s_adr_o,
    output logic [WB_DW-1:0]         s_dat_o,
    output logic [WB_SW-1:0]         s_sel_o,
    input  logic [WB_DW*NSLAVES-1:0] s_dat_i,
    input  logic [NSLAVES-1:0]       s_ack_i,
    input  logic [NSLAVES-1:0]       s_err_i,
    input  logic [NSLAVES-1:0]       s_rty_i,
    output logic [7:0]               err_cnt_o,
    output logic [WB_AW-1:0]         err_adr_o
);

    localparam int IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    state_e            state_q, state_d;
    logic [WB_AW-1:0]  adr_q, adr_d;
    logic [WB_DW-1:0]  wdat_q, wdat_d;
    logic [WB_SW-1:0]  sel_q, sel_d;
    logic              we_q, we_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WB_DW-1:0]  rdat_q, rdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rty_q, rty_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [WB_AW-1:0]  err_adr_q, err_adr_d;

    logic [WB_AW-1:0]  adr_idx;
    logic              idx_ok;
    logic [7:0]        err_cnt_inc;
    logic              sel_ack, sel_err, sel_rty;
    logic [WB_DW-1:0]  sel_dat;
    logic [NSLAVES-1:0] stb_onehot;
    logic              wd_expire;

    assign adr_idx     = wb_extract_idx(adr_i, SEL_MASK);
    assign idx_ok      = adr_idx < 32'(NSLAVES);
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Only the latched slave's response lines and data are ever looked at.
    always_comb begin
        sel_ack    = 1'b0;
        sel_err    = 1'b0;
        sel_rty    = 1'b0;
        sel_dat    = '0;
        stb_onehot = '0;
        for (int k = 0; k < NSLAVES; k++) begin
            if (idx_q == IW'(k)) begin
                sel_ack       = s_ack_i[k];
                sel_err       = s_err_i[k];
                sel_rty       = s_rty_i[k];
                sel_dat       = s_dat_i[WB_DW*k +: WB_DW];
                stb_onehot[k] = 1'b1;
            end
        end
    end

    tisc_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state_q != ACTIVE),
        .en_i     (state_q == ACTIVE),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        idx_d     = idx_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    adr_d  = adr_i;
                    wdat_d = dat_i;
                    sel_d  = sel_i;
                    we_d   = we_i;
                    idx_d  = adr_idx[IW-1:0];
                    if (idx_ok) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d   = RESP;
                        err_d     = 1'b1;
                        rdat_d    = '0;
                        err_cnt_d = err_cnt_inc;
                        err_adr_d = adr_i;
                    end
                end
            end
            ACTIVE: begin
                // A slave response beats a simultaneous watchdog expiry.
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (sel_err || sel_ack || sel_rty) begin
                    state_d = RESP;
                    rdat_d  = sel_dat;
                    err_d   = sel_err;
                    ack_d   = ~sel_err & sel_ack;
                    rty_d   = ~sel_err & ~sel_ack & sel_rty;
                end else if (wd_expire) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rdat_d    = '0;
                    err_cnt_d = err_cnt_inc;
                    err_adr_d = adr_q;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            rdat_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign s_cyc_o   = (state_q == ACTIVE);
    assign s_stb_o   = s_cyc_o ? stb_onehot : '0;
    assign s_we_o    = we_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;
    assign s_sel_o   = sel_q;
    assign dat_o     = rdat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign rty_o     = rty_q;
    assign err_cnt_o = err_cnt_q;
    assign err_adr_o = err_adr_q;

endmodule
